// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor controller.
// Computes a - b one bit per cycle, LSB first, through a single 1-bit
// subtract stage (two half-subtractor cells plus an OR for the borrow) and a
// registered borrow. A start in IDLE or DONE captures the operands. After
// WIDTH RUN cycles, done pulses for one cycle and diff/borrow_out/zero update.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf and the operand-MSB registers that it needs.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             zero,
  output logic             ovf
`else
  output logic             zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic load, step, finish;

  logic [WIDTH-1:0] a_sr, b_sr;
  // Holds the bits already computed. The bit now being computed completes the result.
  logic [WIDTH-2:0] part_sr;
  logic [CW-1:0]    cnt;
  logic             borrow_reg;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  logic ai, bi, bin;
  logic h1_d, h1_b, h2_d, h2_b;
  logic d, bout;
  logic [WIDTH-1:0] shift_tmp;
  logic [WIDTH-1:0] result_full;

  // 1-bit subtract stage: two half-subtractors with their borrows ORed
  always_comb begin
    ai          = a_sr[0];
    bi          = b_sr[0];
    bin         = borrow_reg;
    h1_d        = ai ^ bi;
    h1_b        = ~ai & bi;
    h2_d        = h1_d ^ bin;
    h2_b        = ~h1_d & bin;
    d           = h2_d;
    bout        = h1_b | h2_b;
    shift_tmp   = {d, part_sr};
    result_full = {d, part_sr};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and datapath strobes. DONE accepts a start just as IDLE does.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit shifting, borrow chaining and result load at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      part_sr    <= '0;
      cnt        <= '0;
      borrow_reg <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (load) begin
      a_sr       <= a;
      b_sr       <= b;
      part_sr    <= '0;
      cnt        <= '0;
      borrow_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= a[WIDTH-1];
      b_msb      <= b[WIDTH-1];
`endif
    end else if (step) begin
      a_sr       <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
      part_sr    <= shift_tmp[WIDTH-1:1];
      cnt        <= cnt + 1'b1;
      borrow_reg <= bout;
      if (finish) begin
        diff       <= result_full;
        borrow_out <= bout;
        zero       <= (result_full == '0);
`ifdef SERIAL_SUB_OVF_EN
        ovf        <= (a_msb != b_msb) && (result_full[WIDTH-1] != a_msb);
`endif
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// The expected values were computed by hand. The ovf checks are active only
// when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, borrow_out, zero;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int nChecks = 0;
  int nFails  = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
`ifdef SERIAL_SUB_OVF_EN
    .zero       (zero),
    .ovf        (ovf)
`else
    .zero       (zero)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it does not match
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raises start for one edge with the given operands. Returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB);
    @(negedge clk);
    start = 1'b1;
    a     = opA;
    b     = opB;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks the busy-cycle count and the results.
  // If stayInDone is 0, it also checks that done drops and the DUT is idle on the next cycle.
  task automatic waitDone(input string tag, input int expBusy,
                          input logic [7:0] expDiff, input logic expBorrow,
                          input logic expZero, input logic expOvf, input bit stayInDone);
    int busyCnt = 0;
    int cyc     = 0;
    while (!done && cyc < 20) begin
      if (busy) busyCnt++;
      cyc++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, busyCnt, expBusy);
    checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " busy in done"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " diff"}, {24'd0, diff}, {24'd0, expDiff});
    checkOutput({tag, " borrow_out"}, {31'd0, borrow_out}, {31'd0, expBorrow});
    checkOutput({tag, " zero"}, {31'd0, zero}, {31'd0, expZero});
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, " ovf"}, {31'd0, ovf}, {31'd0, expOvf});
`else
    if (expOvf === 1'bx) $display("[TB] unexpected ovf argument");
`endif
    if (!stayInDone) begin
      @(negedge clk);
      checkOutput({tag, " done drop"}, {31'd0, done}, 32'd0);
      checkOutput({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    bit sawDone;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset diff", {24'd0, diff}, 32'd0);
    checkOutput("reset borrow", {31'd0, borrow_out}, 32'd0);
    checkOutput("reset zero", {31'd0, zero}, 32'd0);
    rst = 1'b0;

    // Basic operation
    applyStimulus(8'h5A, 8'h23);
    checkOutput("basic busy at start", {31'd0, busy}, 32'd1);
    waitDone("basic", 8, 8'h37, 1'b0, 1'b0, 1'b0, 1'b0);

    // Borrow cases
    applyStimulus(8'h10, 8'h20);
    waitDone("borrow", 8, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'hFF);
    waitDone("zero_minus_ff", 8, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    // Equal operands: previous result must stay visible during RUN
    applyStimulus(8'h7F, 8'h7F);
    checkOutput("hold diff", {24'd0, diff}, 32'h01);
    checkOutput("hold borrow", {31'd0, borrow_out}, 32'd1);
    waitDone("equal", 8, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // start held while busy is ignored; then back-to-back start in DONE
    applyStimulus(8'h9C, 8'h1D);
    start = 1'b1;
    a     = 8'h11;
    b     = 8'h22;
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitDone("start_in_run", 5, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b busy", {31'd0, busy}, 32'd1);
    checkOutput("b2b hold diff", {24'd0, diff}, 32'h7F);
    waitDone("b2b", 8, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the 4th RUN cycle discards the operation
    applyStimulus(8'h44, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst done", {31'd0, done}, 32'd0);
    checkOutput("midrst diff", {24'd0, diff}, 32'd0);
    checkOutput("midrst borrow", {31'd0, borrow_out}, 32'd0);
    checkOutput("midrst zero", {31'd0, zero}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("midrst ovf", {31'd0, ovf}, 32'd0);
`endif
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("midrst no done", {31'd0, sawDone}, 32'd0);
    applyStimulus(8'hC8, 8'h64);
    waitDone("after_rst", 8, 8'h64, 1'b0, 1'b0, 1'b1, 1'b0);

    // Signed overflow corner cases
    applyStimulus(8'h80, 8'h01);
    waitDone("ovf_set", 8, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h05, 8'h03);
    waitDone("ovf_clear", 8, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller: computes A − B one bit per cycle, LSB first, through a single 1-bit subtract stage (two half-subtractor cells plus OR for borrow merge) and a registered borrow.
- Sequences the 1-bit datapath: operand capture, bit counter, borrow chaining, result assembly and start/done handshake.
- Area-cheap alternative to a parallel WIDTH-bit subtractor in the arithmetic library.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when ready (state IDLE or DONE)
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse, result valid
- diff  output  WIDTH  result A − B mod 2^WIDTH; updated only at completion
- borrow_out  output  1  final borrow (1 when unsigned A < B)
- zero  output  1  diff == 0, updated with diff
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are clk and rst.
- Reset (rst high at an edge):
  - state to IDLE, bit counter to 0, borrow register to 0.
  - Operand and partial shift registers to 0.
  - busy=0, done=0, diff=0, borrow_out=0, zero=0, ovf=0.
  - rst overrides start and any in-progress operation. Mid-RUN reset discards the operation; no done is produced.
- State machine: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 captures a and b into shift registers, clears borrow and counter, and moves to RUN. Otherwise stay in IDLE.
  - RUN: each edge processes bit 0 of the shifted operands (ai, bi) with the current borrow bin:
    - d = ai ^ bi ^ bin
    - bout = (~ai & bi) | (~(ai ^ bi) & bin)
    - d shifts into the partial result MSB side; operands shift right; borrow register takes bout; counter increments.
  - RUN exit: on the edge where the counter reaches WIDTH−1 (last bit), move to DONE. At that same edge, load diff, borrow_out and zero from the completed result.
  - DONE: done=1 for exactly this one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back); goes to RUN.
    - Otherwise goes to IDLE.
- start while busy=1 is ignored; no queuing. a and b may change freely during RUN.
- Latency: start accepted at E0 gives done high after edge E0+WIDTH. Throughput is one operation per WIDTH cycles when back-to-back.
- Output hold: diff, borrow_out, zero (and ovf) hold their last completed values through IDLE and the next RUN. They change only at completion or reset.
- busy=1 exactly in RUN. done and busy are never both 1.
- Arithmetic: result is modulo 2^WIDTH (two's complement wrap). borrow_out equals the final bout.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - ovf port exists.
  - At completion, ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands; MSBs are retained in a dedicated register.
  - ovf is cleared by reset and held like diff.
- Undefined: the ovf port and its MSB registers are absent. All other behaviour is identical.

Test Plan (WIDTH=8):
- Basic: a=0x5A, b=0x23, start pulse, then no start → busy for 8 cycles; done after 8th edge; diff=0x37, borrow_out=0, zero=0; next cycle done=0, back in IDLE.
- Borrow: a=0x10, b=0x20 → diff=0xF0, borrow_out=1, zero=0. Edge case a=0x00, b=0xFF → diff=0x01, borrow_out=1.
- Equal / zero flag: a=0x7F, b=0x7F → diff=0x00, borrow_out=0, zero=1. Previous diff stays visible throughout RUN until this done.
- Start during RUN and back-to-back:
  - start held high with new operands while busy → ignored; result is still the first pair's.
  - start=1 during DONE with a=0x03, b=0x01 → RUN next cycle; second done 8 cycles later with diff=0x02.
- Reset mid-op: rst high on the 4th RUN cycle → next cycle state IDLE, all outputs 0, no done pulse. New start afterwards computes correctly.
- Overflow (macro defined):
  - a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow_out=0.
  - a=0x05, b=0x03 → ovf=0.
  - Macro undefined: compiles without the ovf port; same diff/borrow results.
